// File: rtl/path_node_mailbox.sv
// path_node_mailbox: CPU-mapped mailbox holding host START/END points and a node FIFO drained to the bot controller.
module path_node_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          DEPTH     = 32,
    parameter int          NODE_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Ext_MemWrite,
    input  logic [31:0]       Ext_DataAdr,
    input  logic [31:0]       Ext_WriteData,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              mbx_hit,
    output logic              node_valid,
    output logic [NODE_W-1:0] node_data,
    input  logic              node_ready,
    output logic              path_done,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]       off, ext_off;
    logic              cpu_node, cpu_done, pop, full, push;
    logic [NODE_W-1:0] start_q, start_d, end_q, end_d, last_q, last_d;
    logic [NODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic              done_q, done_d, ovf_q, ovf_d;
    logic              unused_bits;

    assign off         = DataAdr - BASE_ADDR;
    assign ext_off     = Ext_DataAdr - BASE_ADDR;
    assign unused_bits = ^{WriteData[31:NODE_W], Ext_WriteData[31:NODE_W]};

    always_comb begin
        cpu_node = MemWrite & (off == 32'h8) & ~reset;
        cpu_done = MemWrite & (off == 32'hC);
        pop      = (count_q != '0) & node_ready;
        full     = count_q == CW'(DEPTH);
        // a full FIFO still accepts a push when the head leaves in the same cycle
        push     = cpu_node & (~full | pop);
        wr_d     = push ? wr_q + AW'(1) : wr_q;
        rd_d     = pop ? rd_q + AW'(1) : rd_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        last_d   = cpu_node ? WriteData[NODE_W-1:0] : last_q;
        done_d   = cpu_done ? WriteData[0] : done_q;
        ovf_d    = ovf_q | (cpu_node & full & ~pop);
        start_d  = (Ext_MemWrite && ext_off == 32'h0) ? Ext_WriteData[NODE_W-1:0] : start_q;
        end_d    = (Ext_MemWrite && ext_off == 32'h4) ? Ext_WriteData[NODE_W-1:0] : end_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // host points survive reset so they can be loaded while the CPU is held
    always_ff @(posedge clk) begin
        start_q <= start_d;
        end_q   <= end_d;
        if (push)
            mem[wr_q] <= WriteData[NODE_W-1:0];
    end

    always_comb begin
        mbx_hit    = off < 32'd32;
        node_valid = count_q != '0;
        node_data  = node_valid ? mem[rd_q] : '0;
        path_done  = done_q & ~node_valid;
        overflow   = ovf_q;
        ReadData   = (off == 32'h00) ? 32'(start_q) :
                     (off == 32'h04) ? 32'(end_q) :
                     (off == 32'h08) ? 32'(last_q) :
                     (off == 32'h0C) ? {30'b0, ovf_q, done_q} :
                     (off == 32'h10) ? 32'(count_q) : 32'h0;
    end
endmodule

// File: tb/tb_path_node_mailbox.sv
// tb_path_node_mailbox: directed and random checks of the mailbox against a queue-based reference model.
module tb_path_node_mailbox;
    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam int          DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Ext_MemWrite = 1'b0;
    logic [31:0] Ext_DataAdr = BASE;
    logic [31:0] Ext_WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = BASE + 32'h10;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        mbx_hit, node_valid, path_done, overflow, node_ready = 1'b0;
    logic [4:0]  node_data;

    path_node_mailbox dut (
        .clk(clk), .reset(reset),
        .Ext_MemWrite(Ext_MemWrite), .Ext_DataAdr(Ext_DataAdr), .Ext_WriteData(Ext_WriteData),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
        .mbx_hit(mbx_hit), .node_valid(node_valid), .node_data(node_data),
        .node_ready(node_ready), .path_done(path_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [4:0] q[$];
    logic [4:0] m_start, m_end, m_last;
    logic       m_done, m_ovf;

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] o = a - BASE;
        if (o == 32'h00) return {27'b0, m_start};
        if (o == 32'h04) return {27'b0, m_end};
        if (o == 32'h08) return {27'b0, m_last};
        if (o == 32'h0C) return {30'b0, m_ovf, m_done};
        if (o == 32'h10) return 32'(q.size());
        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // one clock edge of the reference behaviour, using inputs held across the edge
    task automatic model_edge();
        int n = q.size();
        bit pop = (n > 0) && node_ready;
        if (Ext_MemWrite && Ext_DataAdr == BASE)       m_start = Ext_WriteData[4:0];
        if (Ext_MemWrite && Ext_DataAdr == BASE + 4)   m_end   = Ext_WriteData[4:0];
        if (reset) begin
            model_reset();
            return;
        end
        if (pop) void'(q.pop_front());
        if (MemWrite && DataAdr == BASE + 8) begin
            m_last = WriteData[4:0];
            if (n < DEPTH || pop) q.push_back(WriteData[4:0]);
            else m_ovf = 1'b1;
        end
        if (MemWrite && DataAdr == BASE + 12) m_done = WriteData[0];
    endtask

    task automatic check_all();
        check("node_valid", 32'(node_valid), 32'(q.size() > 0));
        check("node_data", 32'(node_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
        check("path_done", 32'(path_done), 32'(m_done && q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("mbx_hit", 32'(mbx_hit), 32'((DataAdr - BASE) < 32'd32));
        check("read", ReadData, exp_read(DataAdr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        model_reset();
        // 1: host loads START/END while reset is held
        Ext_MemWrite = 1'b1;
        Ext_DataAdr = BASE;
        Ext_WriteData = 32'd8;
        tick();
        Ext_DataAdr = BASE + 4;
        Ext_WriteData = 32'd20;
        tick();
        Ext_MemWrite = 1'b0;
        reset = 1'b0;
        tick();
        peek("start", BASE, 32'd8);
        peek("end", BASE + 4, 32'd20);
        peek("status", BASE + 12, 32'd0);
        check("reset_valid", 32'(node_valid), 32'd0);

        // 2: queue three nodes then drain back to back
        cpu_store(BASE + 8, 32'd8);
        cpu_store(BASE + 8, 32'd3);
        cpu_store(BASE + 8, 32'd11);
        peek("count3", BASE + 16, 32'd3);
        peek("last11", BASE + 8, 32'd11);
        check("head8", 32'(node_data), 32'd8);
        node_ready = 1'b1;
        tick();
        check("head3", 32'(node_data), 32'd3);
        tick();
        check("head11", 32'(node_data), 32'd11);
        tick();
        check("drained", 32'(node_valid), 32'd0);

        // 3: DONE set with two nodes queued
        node_ready = 1'b0;
        cpu_store(BASE + 8, 32'd5);
        cpu_store(BASE + 8, 32'd6);
        cpu_store(BASE + 12, 32'd1);
        check("done_busy", 32'(path_done), 32'd0);
        node_ready = 1'b1;
        tick();
        check("done_one_left", 32'(path_done), 32'd0);
        tick();
        check("done_set", 32'(path_done), 32'd1);

        // 4: fill, overflow with 9, then push+pop at full
        node_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) cpu_store(BASE + 8, 32'(i % 8));
        cpu_store(BASE + 8, 32'd9);
        check("ovf", 32'(overflow), 32'd1);
        peek("count_full", BASE + 16, 32'(DEPTH));
        node_ready = 1'b1;
        cpu_store(BASE + 8, 32'd7);
        peek("count_pp", BASE + 16, 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("no9", 32'(node_data == 5'd9), 32'd0);
            tick();
        end
        check("empty_again", 32'(node_valid), 32'd0);

        // 5: asynchronous reset with nodes queued and DONE set
        node_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_store(BASE + 8, 32'(i + 1));
        cpu_store(BASE + 12, 32'd1);
        DataAdr = BASE + 16;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_valid", 32'(node_valid), 32'd0);
        check("arst_done", 32'(path_done), 32'd0);
        check("arst_count", ReadData, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        peek("start_kept", BASE, 32'd8);
        peek("end_kept", BASE + 4, 32'd20);

        // 6: CPU cannot write START, out-of-window store is ignored
        cpu_store(BASE, 32'd30);
        peek("start_cpu", BASE, 32'd8);
        cpu_store(BASE + 32, 32'd4);
        check("hit20", 32'(mbx_hit), 32'd0);
        peek("count_untouched", BASE + 16, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int sel = int'($urandom_range(0, 9));
            logic [31:0] offs[10] = '{0, 4, 8, 8, 8, 12, 16, 20, 2, 32};
            MemWrite = $urandom_range(0, 1) == 1;
            DataAdr = BASE + offs[sel];
            WriteData = $urandom;
            node_ready = $urandom_range(0, 2) != 0;
            Ext_MemWrite = $urandom_range(0, 3) == 0;
            Ext_DataAdr = BASE + 32'(4 * $urandom_range(0, 3));
            Ext_WriteData = $urandom;
            tick();
        end
        MemWrite = 1'b0;
        Ext_MemWrite = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
